dwt53_row_lift: RTL and testbench

Streaming first-dimension LeGall 5/3 integer lifting stage that sits directly upstream of the two-dimensional DWT core. It accepts raw unsigned pixels one per beat in row-major order and emits one (low, high) coefficient pair per two input pixels. Boundaries use whole-sample symmetric extension. Its coefficient output feeds the column (second-dimension) pass, and it reports row and frame completion.

---
 rtl/dwt53_row_lift.sv | 135 +++++++++++++
 tb/tb_dwt53_row_lift.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwt53_row_lift.sv
// Streaming row-direction LeGall 5/3 integer lifting stage with whole-sample symmetric
// extension; emits one (low, high) coefficient pair per two accepted pixels.
module dwt53_row_lift #(
    parameter int DATA_W  = 8,
    parameter int COEF_W  = DATA_W + 2,
    parameter int ROW_LEN = 8,
    parameter int ROWS    = 8,
    parameter int IDX_W   = $clog2(ROW_LEN / 2)
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [COEF_W-1:0] out_low,
    output logic signed [COEF_W-1:0] out_high,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     frame_done
);

    localparam int K_W   = $clog2(ROW_LEN);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ACC_W = COEF_W + 2;
    localparam logic signed [ACC_W-1:0] C_TWO = ACC_W'(2);

    logic [K_W-1:0]            r_k;
    logic [ROW_W-1:0]          r_row;
    logic [DATA_W-1:0]         r_even_prev;
    logic [DATA_W-1:0]         r_odd;
    logic signed [COEF_W-1:0]  r_d_prev;
    logic                      r_out_valid;
    logic signed [COEF_W-1:0]  r_out_low;
    logic signed [COEF_W-1:0]  r_out_high;
    logic [IDX_W-1:0]          r_out_idx;
    logic                      r_out_last;
    logic                      r_out_eof;
    logic                      r_frame_done;

    logic                      w_accept;
    logic                      w_is_last;
    logic                      w_emit;
    logic [DATA_W-1:0]         w_odd_px;
    logic [DATA_W-1:0]         w_right_px;
    logic signed [ACC_W-1:0]   w_even_ext;
    logic signed [ACC_W-1:0]   w_odd_ext;
    logic signed [ACC_W-1:0]   w_right_ext;
    logic signed [ACC_W-1:0]   w_d_full;
    logic signed [ACC_W-1:0]   w_d_left;
    logic signed [COEF_W-1:0]  w_d;
    logic signed [COEF_W-1:0]  w_s;
    logic [K_W-1:0]            w_half;
    logic [IDX_W-1:0]          w_idx;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_is_last = (r_k == K_W'(ROW_LEN - 1));
    assign w_emit    = w_accept && (((r_k[0] == 1'b0) && (r_k != '0)) || w_is_last);

    // At the last column the odd sample is the incoming pixel and the right even
    // neighbour mirrors back to x[ROW_LEN-2], which is still held in r_even_prev.
    assign w_odd_px    = w_is_last ? in_data : r_odd;
    assign w_right_px  = w_is_last ? r_even_prev : in_data;
    assign w_even_ext  = $signed({{(ACC_W - DATA_W){1'b0}}, r_even_prev});
    assign w_odd_ext   = $signed({{(ACC_W - DATA_W){1'b0}}, w_odd_px});
    assign w_right_ext = $signed({{(ACC_W - DATA_W){1'b0}}, w_right_px});

    assign w_d_full = w_odd_ext - ((w_even_ext + w_right_ext) >>> 1);
    assign w_d_left = (r_k == K_W'(2)) ? w_d_full : ACC_W'(r_d_prev);
    assign w_d      = COEF_W'(w_d_full);
    assign w_s      = COEF_W'(w_even_ext + ((w_d_left + w_d_full + C_TWO) >>> 2));

    assign w_half = r_k >> 1;
    assign w_idx  = w_is_last ? IDX_W'(w_half) : IDX_W'(w_half - 1'b1);

    // NOTE: every register here, including the output data, is cleared on reset so the
    // outputs read zero afterwards; all state uses non-blocking assignments.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_k          <= '0;
            r_row        <= '0;
            r_even_prev  <= '0;
            r_odd        <= '0;
            r_d_prev     <= '0;
            r_out_valid  <= 1'b0;
            r_out_low    <= '0;
            r_out_high   <= '0;
            r_out_idx    <= '0;
            r_out_last   <= 1'b0;
            r_out_eof    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_is_last) begin
                    r_k   <= '0;
                    r_row <= (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;
                end else begin
                    r_k <= r_k + 1'b1;
                end

                if (r_k == '0) begin
                    r_even_prev <= in_data;
                end else if (r_k[0] && !w_is_last) begin
                    r_odd <= in_data;
                end else if (!w_is_last) begin
                    r_even_prev <= in_data;
                    r_d_prev    <= w_d;
                end
            end

            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_low   <= w_s;
                r_out_high  <= w_d;
                r_out_idx   <= w_idx;
                r_out_last  <= w_is_last;
                r_out_eof   <= w_is_last && (r_row == ROW_W'(ROWS - 1));
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            r_frame_done <= r_out_valid && out_ready && r_out_last && r_out_eof;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_low    = r_out_low;
    assign out_high   = r_out_high;
    assign out_idx    = r_out_idx;
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_dwt53_row_lift.sv
// Directed bench for dwt53_row_lift: hand-computed 5/3 pairs, backpressure, mid-row
// reset and frame completion with a two-row frame.
module tb_dwt53_row_lift;

    localparam int DATA_W  = 8;
    localparam int COEF_W  = 10;
    localparam int ROW_LEN = 8;
    localparam int ROWS    = 2;
    localparam int IDX_W   = 2;

    logic                     sys_clk = 1'b0;
    logic                     sys_rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [COEF_W-1:0] out_low;
    logic signed [COEF_W-1:0] out_high;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_last;
    logic                     frame_done;

    dwt53_row_lift #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ROW_LEN(ROW_LEN),
        .ROWS   (ROWS),
        .IDX_W  (IDX_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_low   (out_low),
        .out_high  (out_high),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int lo;
        int hi;
        int idx;
        int last;
    } pair_t;

    pair_t q[$];
    int    cyc = 0;
    int    n_last = 0;
    int    last_cyc = 0;
    int    fd_cnt = 0;
    int    fd_delta = 0;
    int    fd_lasts = 0;
    int    n_vec = 0;
    int    n_err = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Capture every handshaken pair and every frame_done pulse.
    always @(negedge sys_clk) begin
        if (out_valid && out_ready) begin
            q.push_back('{int'(out_low), int'(out_high), int'(out_idx), int'(out_last)});
            if (out_last) begin
                n_last   = n_last + 1;
                last_cyc = cyc;
            end
        end
        if (frame_done) begin
            fd_cnt   = fd_cnt + 1;
            fd_delta = cyc - last_cyc;
            fd_lasts = n_last;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_pixel(input int x);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = DATA_W'(x);
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge sys_clk);
            acc = in_ready;
            @(posedge sys_clk);
            #1;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $error("FAIL accept_timeout: observed in_ready=0 expected pixel %0d accepted", x);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic send_row(input int px[8]);
        for (int i = 0; i < 8; i++) send_pixel(px[i]);
    endtask

    task automatic do_reset();
        idle();
        out_ready = 1'b1;
        sys_rst   = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        q.delete();
    endtask

    task automatic wait_pairs(input int n);
        for (int t = 0; t < 100 && q.size() < n; t++) begin
            @(posedge sys_clk);
            #1;
        end
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic check_pairs(input string name, input int lo[4], input int hi[4]);
        pair_t p;
        wait_pairs(4);
        check($sformatf("%s_count", name), q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (q.size() > 0) begin
                p = q.pop_front();
                check($sformatf("%s_low%0d", name, i), p.lo, lo[i]);
                check($sformatf("%s_high%0d", name, i), p.hi, hi[i]);
                check($sformatf("%s_idx%0d", name, i), p.idx, i);
                check($sformatf("%s_last%0d", name, i), p.last, (i == 3) ? 1 : 0);
            end
        end
        q.delete();
    endtask

    initial begin
        pair_t p;
        int    fd_base;
        int    last_base;

        // Reset state.
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_low", int'(out_low), 0);
        check("rst_out_high", int'(out_high), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_frame_done", int'(frame_done), 0);

        // Constant row, with first-pair latency.
        do_reset();
        send_pixel(100);
        send_pixel(100);
        check("lat_no_pair_yet", int'(out_valid), 0);
        send_pixel(100);
        check("lat_pair0_valid", int'(out_valid), 1);
        check("lat_pair0_idx", int'(out_idx), 0);
        for (int i = 3; i < 8; i++) send_pixel(100);
        idle();
        check_pairs("const100", '{100, 100, 100, 100}, '{0, 0, 0, 0});

        // Ramp: right-boundary mirror.
        do_reset();
        send_row('{0, 1, 2, 3, 4, 5, 6, 7});
        idle();
        check_pairs("ramp", '{0, 2, 4, 6}, '{0, 0, 0, 1});

        // Alternating rows: signed floor shift.
        do_reset();
        send_row('{255, 0, 255, 0, 255, 0, 255, 0});
        idle();
        check_pairs("alt_hi", '{128, 128, 128, 128}, '{-255, -255, -255, -255});
        do_reset();
        send_row('{0, 255, 0, 255, 0, 255, 0, 255});
        idle();
        check_pairs("alt_lo", '{128, 128, 128, 128}, '{255, 255, 255, 255});

        // Backpressure while pair 1 is valid.
        do_reset();
        for (int i = 0; i < 5; i++) send_pixel(i);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            check($sformatf("bp_in_ready_c%0d", c), int'(in_ready), 0);
            check($sformatf("bp_valid_c%0d", c), int'(out_valid), 1);
            check($sformatf("bp_low_c%0d", c), int'(out_low), 2);
            check($sformatf("bp_high_c%0d", c), int'(out_high), 0);
            check($sformatf("bp_idx_c%0d", c), int'(out_idx), 1);
            @(posedge sys_clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 5; i < 8; i++) send_pixel(i);
        idle();
        check_pairs("bp_ramp", '{0, 2, 4, 6}, '{0, 0, 0, 1});

        // Reset mid-row discards the partial row and the pending pair.
        do_reset();
        for (int i = 0; i < 3; i++) send_pixel(i);
        idle();
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        q.delete();
        send_row('{50, 50, 50, 50, 50, 50, 50, 50});
        idle();
        check_pairs("midrst_const50", '{50, 50, 50, 50}, '{0, 0, 0, 0});

        // Two back-to-back rows complete a frame.
        do_reset();
        fd_base   = fd_cnt;
        last_base = n_last;
        send_row('{60, 60, 60, 60, 60, 60, 60, 60});
        send_row('{60, 60, 60, 60, 60, 60, 60, 60});
        idle();
        wait_pairs(8);
        check("frame_count", q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (q.size() > 0) begin
                p = q.pop_front();
                check($sformatf("frame_low%0d", i), p.lo, 60);
                check($sformatf("frame_high%0d", i), p.hi, 0);
                check($sformatf("frame_idx%0d", i), p.idx, i % 4);
                check($sformatf("frame_last%0d", i), p.last, (i % 4 == 3) ? 1 : 0);
            end
        end
        check("frame_done_pulses", fd_cnt - fd_base, 1);
        check("frame_done_after_row2", fd_lasts - last_base, 2);
        check("frame_done_delay", fd_delta, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
